// File: rtl/fp32_tb_pkg.sv
// Shared types, constants and helpers for the fp32 multiplier stimulus generator.
package fp32_tb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCorner,
    StRandom,
    StDrain,
    StDone
  } state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  // {x1, x2} per entry
  localparam logic [63:0] CORNER_TBL [8] = '{
    {32'h3F800000, 32'h3F800000},
    {32'h40000000, 32'h40400000},
    {32'hBFC00000, 32'h40000000},
    {32'h00000000, 32'h3F800000},
    {32'h3FFFFFFF, 32'h3FFFFFFF},
    {32'h7E800000, 32'h3F000000},
    {32'h00800000, 32'h40000000},
    {32'h3F800001, 32'h3F7FFFFF}
  };

  function automatic logic [31:0] lfsr_next(input logic [31:0] r);
    return r[0] ? ((r >> 1) ^ LFSR_TAPS) : (r >> 1);
  endfunction

  // Out-of-window exponents fold into [lo, lo+63], which the caller keeps inside [lo, hi].
  function automatic logic [7:0] fold_exp(input logic [7:0] e, input logic [7:0] lo,
                                          input logic [7:0] hi);
    if (e < lo || e > hi) return lo + {2'b00, e[5:0]};
    return e;
  endfunction

endpackage

// File: rtl/fp32_mul_stim_gen_if.sv
// Stimulus/checker handshake bundle: operands, valid, end-of-run and run control.
interface fp32_mul_stim_gen_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             pause;
  logic [31:0]      x1;
  logic [31:0]      x2;
  logic             val;
  logic             over;
  logic             busy;
  logic [CNT_W-1:0] vec_cnt;

  modport master (
    input  start, pause,
    output x1, x2, val, over, busy, vec_cnt
  );

  modport slave (
    output start, pause,
    input  x1, x2, val, over, busy, vec_cnt
  );
endinterface

// File: rtl/fp32_lfsr_operand.sv
// Galois LFSR producing a normal-range fp32 operand from its post-step value.
module fp32_lfsr_operand
  import fp32_tb_pkg::*;
#(
  parameter logic [31:0] SEED   = 32'hACE12468,
  parameter logic [7:0]  EXP_LO = 8'd64,
  parameter logic [7:0]  EXP_HI = 8'd190
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  output logic [31:0] operand
);

  localparam logic [31:0] SeedNz = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SeedNz;
    end else if (load) begin
      lfsr_q <= SeedNz;
    end else if (step) begin
      lfsr_q <= lfsr_nxt;
    end
  end

  always_comb begin
    lfsr_nxt = lfsr_next(lfsr_q);
    operand  = {lfsr_nxt[31], fold_exp(lfsr_nxt[30:23], EXP_LO, EXP_HI), lfsr_nxt[22:0]};
  end

endmodule

// File: rtl/fp32_mul_stim_gen.sv
// Stimulus source for the fp32 multiplier: corner table, LFSR randoms, drain, then an over pulse.
module fp32_mul_stim_gen
  import fp32_tb_pkg::*;
#(
  parameter int unsigned NUM_RANDOM = 1000,
  parameter logic [31:0] SEED       = 32'hACE12468,
  parameter int unsigned LAT        = 4,
  parameter logic [7:0]  EXP_LO     = 8'd64,
  parameter logic [7:0]  EXP_HI     = 8'd190,
  parameter int unsigned CNT_W      = 16
) (
  input logic                 clk,
  input logic                 rst,
  fp32_mul_stim_gen_if.master bus
);

  localparam int unsigned     DrainW    = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(LAT);
  localparam logic [CNT_W-1:0]  LastCnt   = CNT_W'(NUM_RANDOM + 7);

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DrainW-1:0]  drain_q, drain_d;
  logic [31:0]        x1_q, x1_d, x2_q, x2_d;
  logic               val_q, val_d, over_q, over_d, busy_q, busy_d;
  logic               load, step;
  logic [31:0]        op_a, op_b;

  fp32_lfsr_operand #(
    .SEED   (SEED),
    .EXP_LO (EXP_LO),
    .EXP_HI (EXP_HI)
  ) u_lfsr_a (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .operand (op_a)
  );

  fp32_lfsr_operand #(
    .SEED   (~SEED),
    .EXP_LO (EXP_LO),
    .EXP_HI (EXP_HI)
  ) u_lfsr_b (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .operand (op_b)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    val_d   = 1'b0;
    over_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = StCorner;
          idx_d   = 3'd0;
          cnt_d   = '0;
          drain_d = '0;
          // The first table entry goes out on the start edge itself unless paused.
          if (!bus.pause) begin
            {x1_d, x2_d} = CORNER_TBL[0];
            val_d        = 1'b1;
            idx_d        = 3'd1;
            cnt_d        = CNT_W'(1);
          end
        end
      end
      StCorner: begin
        if (!bus.pause) begin
          {x1_d, x2_d} = CORNER_TBL[idx_q];
          val_d        = 1'b1;
          idx_d        = idx_q + 3'd1;
          cnt_d        = cnt_q + CNT_W'(1);
          if (idx_q == 3'd7) state_d = (NUM_RANDOM == 0) ? StDrain : StRandom;
        end
      end
      StRandom: begin
        if (!bus.pause) begin
          step  = 1'b1;
          x1_d  = op_a;
          x2_d  = op_b;
          val_d = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LastCnt) state_d = StDrain;
        end
      end
      StDrain: begin
        if (!bus.pause) begin
          if (drain_q == DrainLast) begin
            over_d  = 1'b1;
            state_d = StDone;
          end else begin
            drain_d = drain_q + DrainW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StCorner) || (state_d == StRandom) || (state_d == StDrain);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      cnt_q   <= '0;
      drain_q <= '0;
      x1_q    <= 32'h0;
      x2_q    <= 32'h0;
      val_q   <= 1'b0;
      over_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      val_q   <= val_d;
      over_q  <= over_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.x1      = x1_q;
  assign bus.x2      = x2_q;
  assign bus.val     = val_q;
  assign bus.over    = over_q;
  assign bus.busy    = busy_q;
  assign bus.vec_cnt = cnt_q;

endmodule

// File: tb/tb_fp32_mul_stim_gen.sv
// Bench for fp32_mul_stim_gen: corner-table timing, LFSR golden scoreboard, pause, restart, reset.
module tb_fp32_mul_stim_gen;

  localparam int unsigned NR    = 1000;
  localparam int unsigned LAT   = 4;
  localparam int unsigned TOTAL = NR + 8;
  localparam logic [31:0] SEED  = 32'hACE12468;

  typedef struct {
    int unsigned cyc;
    logic [31:0] x1;
    logic [31:0] x2;
  } vec_t;

  typedef struct {
    logic [31:0] x1;
    logic [31:0] x2;
  } pair_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp32_mul_stim_gen_if #(.CNT_W(16)) bus ();
  fp32_mul_stim_gen_if #(.CNT_W(16)) bus0 ();

  fp32_mul_stim_gen #(
    .NUM_RANDOM (NR),
    .SEED       (SEED),
    .LAT        (LAT),
    .EXP_LO     (8'd64),
    .EXP_HI     (8'd190),
    .CNT_W      (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fp32_mul_stim_gen #(
    .NUM_RANDOM (0),
    .SEED       (SEED),
    .LAT        (LAT),
    .EXP_LO     (8'd64),
    .EXP_HI     (8'd190),
    .CNT_W      (16)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  int    n_pass = 0;
  int    n_total = 0;
  int    cyc = 0;
  int    mon_vals = 0;
  int    last_val_cyc = 0;
  int    over_cnt = 0;
  pair_t exp_q[$];
  pair_t mon_p;
  vec_t  corner[8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [31:0] g_step(input logic [31:0] r);
    logic lsb;
    lsb = r[0];
    r = {1'b0, r[31:1]};
    if (lsb) r = r ^ 32'h80200003;
    return r;
  endfunction

  function automatic logic [31:0] g_form(input logic [31:0] r);
    logic [7:0] e;
    e = r[30:23];
    if (e < 8'd64 || e > 8'd190) e = 8'd64 + (e & 8'h3F);
    return {r[31], e, r[22:0]};
  endfunction

  task automatic push_run();
    logic [31:0] a, b;
    pair_t p;
    a = SEED;
    b = ~SEED;
    for (int i = 0; i < 8; i++) begin
      p.x1 = corner[i].x1;
      p.x2 = corner[i].x2;
      exp_q.push_back(p);
    end
    for (int i = 0; i < int'(NR); i++) begin
      a = g_step(a);
      b = g_step(b);
      p.x1 = g_form(a);
      p.x2 = g_form(b);
      exp_q.push_back(p);
    end
  endtask

  // Scoreboard monitor for the main instance
  always @(negedge clk) begin
    if (bus.val) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        mon_p = exp_q.pop_front();
        chk("sb_pair", {bus.x1, bus.x2}, {mon_p.x1, mon_p.x2});
      end
      if (mon_vals >= 8) begin
        int e1, e2, s;
        logic ok;
        e1 = int'(bus.x1[30:23]);
        e2 = int'(bus.x2[30:23]);
        s  = e1 + e2 - 127;
        ok = (e1 >= 64) && (e1 <= 190) && (e2 >= 64) && (e2 <= 190) && (s >= 1) && (s <= 253);
        chk("rnd_exp_range", 64'(ok), 64'd1);
      end
      mon_vals++;
      last_val_cyc = cyc;
    end
    if (bus.over) over_cnt++;
  end

  task automatic wait_over(input string name);
    for (int i = 0; i < 3000 && !bus.over; i++) @(negedge clk);
    chk(name, 64'(bus.over), 64'd1);
  endtask

  initial begin
    int ov;
    corner[0] = '{1, 32'h3F800000, 32'h3F800000};
    corner[1] = '{2, 32'h40000000, 32'h40400000};
    corner[2] = '{3, 32'hBFC00000, 32'h40000000};
    corner[3] = '{4, 32'h00000000, 32'h3F800000};
    corner[4] = '{5, 32'h3FFFFFFF, 32'h3FFFFFFF};
    corner[5] = '{6, 32'h7E800000, 32'h3F000000};
    corner[6] = '{7, 32'h00800000, 32'h40000000};
    corner[7] = '{8, 32'h3F800001, 32'h3F7FFFFF};

    bus.start = 1'b0;  bus.pause = 1'b0;
    bus0.start = 1'b0; bus0.pause = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ops", {bus.x1, bus.x2}, 64'd0);
    chk("rst_flags", {bus.val, bus.over, bus.busy, bus.vec_cnt}, 64'd0);
    chk("rst_ops0", {bus0.x1, bus0.x2}, 64'd0);
    chk("rst_flags0", {bus0.val, bus0.over, bus0.busy, bus0.vec_cnt}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // NUM_RANDOM=0 instance: start during cycle 0, watch cycles 1..14
    bus0.start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      logic ve, oe, be;
      @(negedge clk);
      bus0.start = 1'b0;
      ve = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (corner[k].cyc == c) begin
          ve = 1'b1;
          chk("nr0_ops", {bus0.x1, bus0.x2}, {corner[k].x1, corner[k].x2});
        end
      end
      oe = (c == 13);
      be = (c <= 12);
      chk("nr0_flags", {bus0.val, bus0.over, bus0.busy}, {ve, oe, be});
      if (c == 9) chk("nr0_vec_cnt", 64'(bus0.vec_cnt), 64'd8);
    end

    // Run 1: start held high, pause at vector 20
    mon_vals = 0;
    exp_q.delete();
    push_run();
    bus.start = 1'b1;
    for (int i = 0; i < 200 && bus.vec_cnt != 16'd20; i++) @(negedge clk);
    chk("wait_vec20", 64'(bus.vec_cnt), 64'd20);
    bus.pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("pause_hold", {bus.val, bus.vec_cnt}, {1'b0, 16'd20});
    end
    bus.pause = 1'b0;
    wait_over("run1_over");
    bus.start = 1'b0;
    chk("run1_drain_lat", 64'(cyc - last_val_cyc), 64'(LAT + 1));
    chk("run1_val_total", 64'(mon_vals), 64'(TOTAL));
    chk("run1_vec_cnt", 64'(bus.vec_cnt), 64'(TOTAL));
    chk("run1_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("run1_busy_at_over", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("run1_done", {bus.val, bus.over, bus.busy}, 64'd0);

    // Run 2: restart from DONE reproduces the same sequence
    mon_vals = 0;
    push_run();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_over("run2_over");
    chk("run2_drain_lat", 64'(cyc - last_val_cyc), 64'(LAT + 1));
    chk("run2_val_total", 64'(mon_vals), 64'(TOTAL));
    chk("run2_sb_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);

    // Run 3: reset asserted during drain
    mon_vals = 0;
    push_run();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3000 && !(bus.busy && bus.vec_cnt == 16'(TOTAL) && !bus.val); i++)
      @(negedge clk);
    chk("reach_drain", {bus.busy, bus.val, bus.vec_cnt}, {1'b1, 1'b0, 16'(TOTAL)});
    ov = over_cnt;
    rst = 1'b0;
    #1;
    chk("midrst_ops", {bus.x1, bus.x2}, 64'd0);
    chk("midrst_flags", {bus.val, bus.over, bus.busy, bus.vec_cnt}, 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {bus.val, bus.over, bus.busy}, 64'd0);
    end
    chk("no_over_after_rst", 64'(over_cnt), 64'(ov));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fp32_mul_stim_gen.md
Name: fp32_mul_stim_gen

Overview:
Synthesizable stimulus source for the fp32 multiplier pipeline, the producer side of the x1/x2/val/over checking interface.
- Issues a fixed table of 8 corner-case operand pairs, then NUM_RANDOM pseudo-random normal-range pairs from LFSRs.
- After the last vector, drains the multiplier latency, then pulses `over` so the downstream checker ends the run.
- Sits at the top of the multiplier testbench and drives both the DUT inputs and the checker's delayed-compare inputs.

Parameters:
NUM_RANDOM, 1000, number of random vectors after the corner table; must be ≤ 2^CNT_W − 9.
SEED, 32'hACE12468, LFSR A seed; LFSR B seed = ~SEED; a zero seed is replaced by 32'h1.
LAT, 4, drain cycles after the last vector; equals the multiplier latency.
EXP_LO, 8'd64, minimum biased exponent of random operands.
EXP_HI, 8'd190, maximum biased exponent; EXP_HI − EXP_LO ≥ 63 is required.
CNT_W, 16, width of vec_cnt.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  begin run; sampled only in IDLE or DONE
pause  in  1  hold generation; val forced 0, state/LFSR/counters frozen
x1  out  32  operand 1, IEEE-754 single
x2  out  32  operand 2
val  out  1  x1/x2 valid this cycle
over  out  1  one-cycle end-of-run pulse
busy  out  1  high in CORNER, RANDOM, DRAIN
vec_cnt  out  CNT_W  vectors issued since last start

Behaviour:
- Reset (rst=0, async): x1=0, x2=0, val=0, over=0, busy=0, vec_cnt=0, state=IDLE, LFSR A=SEED, LFSR B=~SEED (zero → 1).
- All outputs are registered.
- FSM states: IDLE, CORNER, RANDOM, DRAIN, DONE.
- IDLE/DONE with start=1 at edge t:
  - go to CORNER; reload LFSRs from seed; clear vec_cnt and the table index.
  - First vector is valid in the cycle after edge t (val=1).
- CORNER: each unpaused cycle drives table[idx], val=1, then idx++ and vec_cnt++. After idx 7 → RANDOM, or → DRAIN if NUM_RANDOM=0.
- Corner table (x1, x2):
  - 0: 3F800000, 3F800000
  - 1: 40000000, 40400000
  - 2: BFC00000, 40000000
  - 3: 00000000, 3F800000
  - 4: 3FFFFFFF, 3FFFFFFF
  - 5: 7E800000, 3F000000
  - 6: 00800000, 40000000
  - 7: 3F800001, 3F7FFFFF
- RANDOM: each unpaused cycle both LFSRs step once (Galois, taps 32'h80200003). The operand is formed from the post-step value r:
  - sign = r[31]; mantissa = r[22:0]; e = r[30:23].
  - If e < EXP_LO or e > EXP_HI, then e = EXP_LO + {2'b0, e[5:0]}.
  - This guarantees a normal, non-overflowing product.
  - vec_cnt++. After NUM_RANDOM vectors → DRAIN.
- DRAIN: val=0 for LAT unpaused cycles, then over=1 for exactly one cycle and → DONE. busy=0 from that same cycle.
- DONE: x1/x2 hold the last value, val=0, over=0.
- pause=1: val=0 in that cycle; idx, LFSRs, vec_cnt and the drain counter hold; over is never asserted while pause=1.
- start while busy is ignored; start with pause=1 in IDLE still starts, but no vector issues until pause=0.
- x1/x2 are don't-care when val=0; the implementation holds the last values.
- Reset mid-run aborts immediately; no over pulse is generated.

Decomposition:
- Package fp32_tb_pkg:
  - fsm state enum.
  - corner-table constant array (8×2×32).
  - LFSR tap constant.
  - function `fold_exp` (exponent folding).
  - function `lfsr_next`.
- Sub-module fp32_lfsr_operand (seed param, step enable, 32-bit operand out), instantiated twice.

Test Plan:
- Reset, start pulse at cycle 0:
  - val=1 on cycles 1..8 with table pairs in order; vec_cnt = 8 at cycle 9.
- NUM_RANDOM=0, LAT=4:
  - last val at cycle 8; cycles 9–12 val=0; over=1 only at cycle 13; busy=0 from cycle 13.
- NUM_RANDOM=1000, SEED default:
  - exactly 1008 val cycles.
  - every random exponent lies in 64..190, and x1[30:23]+x2[30:23]−127 lies in 1..253.
  - over after 4 drain cycles; golden LFSR model matches all operands.
- pause=1 for 5 cycles during RANDOM at vector 20:
  - val=0 for those cycles; vector 20 issues unchanged after release; total val count is still 1008.
- start held high throughout the run: no restart until DONE. start in DONE restarts with identical operand sequence (same SEED).
- rst=0 asserted during DRAIN: all outputs 0 immediately; over never pulses; state IDLE.
